// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared widths, constants and state encoding for the memory controller
package mem_ctrl_pkg;

  localparam int ADDR_W   = 32;
  localparam int INSTRLEN = 32;
  localparam int CNT_W    = 5;

  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 32'h30000;

  localparam logic        TRUE   = 1'b1;
  localparam logic        FALSE  = 1'b0;
  localparam logic [31:0] NULL32 = 32'h0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - two-way round-robin grant between ICache fills and LSB accesses
module mem_ctrl_arb (
  input  logic clk,
  input  logic rst,
  input  logic icache_req,
  input  logic lsb_req,
  input  logic suppress,
  output logic gnt_icache,
  output logic gnt_lsb
);

  logic lsb_next_q, lsb_next_d;

  always_comb begin
    gnt_lsb    = ~suppress & lsb_req & (~icache_req | lsb_next_q);
    gnt_icache = ~suppress & icache_req & ~gnt_lsb;
    lsb_next_d = lsb_next_q;
    if (gnt_lsb) begin
      lsb_next_d = 1'b0;
    end else if (gnt_icache) begin
      lsb_next_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsb_next_q <= 1'b1;
    end else begin
      lsb_next_q <= lsb_next_d;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM/IO port sequencer shared by ICache fills and LSB loads/stores
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                LINE_BYTES = 4,
  parameter logic [ADDR_W-1:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    icache_req,
  input  logic [ADDR_W-1:0]       icache_addr,
  output logic                    icache_done,
  output logic [8*LINE_BYTES-1:0] icache_data,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [ADDR_W-1:0]       lsb_addr,
  input  logic [2:0]              lsb_len,
  input  logic [INSTRLEN-1:0]     lsb_wdata,
  output logic                    lsb_done,
  output logic [INSTRLEN-1:0]     lsb_rdata,
  input  logic                    flush,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int BUF_BYTES = (LINE_BYTES > 4) ? LINE_BYTES : 4;
  localparam int BUF_W     = 8 * BUF_BYTES;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic                    is_icache_q, is_icache_d;
  logic [ADDR_W-1:0]       mem_a_q, mem_a_d;
  logic [7:0]              mem_dout_q, mem_dout_d;
  logic [INSTRLEN-1:0]     wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    icache_done_q, icache_done_d;
  logic                    lsb_done_q, lsb_done_d;
  logic [8*LINE_BYTES-1:0] icache_data_q, icache_data_d;
  logic [INSTRLEN-1:0]     lsb_rdata_q, lsb_rdata_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic                    stall, arb_suppress, gnt_icache, gnt_lsb;

  assign stall        = io_buffer_full & (mem_a_q >= IO_BASE);
  assign arb_suppress = (state_q != ST_IDLE) | flush | ~rdy;

  assign mem_wr      = wr_q & rdy & ~stall;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign icache_done = icache_done_q;
  assign icache_data = icache_data_q;
  assign lsb_done    = lsb_done_q;
  assign lsb_rdata   = lsb_rdata_q;

  mem_ctrl_arb u_arb (
    .clk        (clk),
    .rst        (rst),
    .icache_req (icache_req),
    .lsb_req    (lsb_req),
    .suppress   (arb_suppress),
    .gnt_icache (gnt_icache),
    .gnt_lsb    (gnt_lsb)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    is_icache_d   = is_icache_q;
    mem_a_d       = mem_a_q;
    mem_dout_d    = mem_dout_q;
    wdata_d       = wdata_q;
    wr_d          = wr_q;
    icache_done_d = FALSE;
    lsb_done_d    = FALSE;
    icache_data_d = icache_data_q;
    lsb_rdata_d   = lsb_rdata_q;
    buf_d         = buf_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_icache) begin
          is_icache_d = TRUE;
          len_d       = CNT_W'(LINE_BYTES);
          cnt_d       = '0;
          mem_a_d     = icache_addr;
          buf_d       = '0;
          state_d     = ST_READ;
        end else if (gnt_lsb) begin
          is_icache_d = FALSE;
          len_d       = {{(CNT_W-3){1'b0}}, lsb_len};
          cnt_d       = '0;
          mem_a_d     = lsb_addr;
          buf_d       = '0;
          if (lsb_wr) begin
            wr_d       = TRUE;
            mem_dout_d = lsb_wdata[7:0];
            wdata_d    = lsb_wdata >> 8;
            state_d    = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          // mem_din lags mem_a by one cycle, so count value k+1 lands byte k
          for (int i = 0; i < BUF_BYTES; i++) begin
            if (cnt_q == CNT_W'(i + 1)) begin
              buf_d[8*i +: 8] = mem_din;
            end
          end
          if (cnt_q == len_q) begin
            state_d = ST_DONE;
            if (is_icache_q) begin
              icache_done_d = TRUE;
              icache_data_d = buf_d[8*LINE_BYTES-1:0];
            end else begin
              lsb_done_d  = TRUE;
              lsb_rdata_d = buf_d[INSTRLEN-1:0];
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            mem_a_d = mem_a_q + ADDR_W'(1);
          end
        end
      end
      ST_WRITE: begin
        if (!stall) begin
          if (cnt_q == len_q - CNT_W'(1)) begin
            wr_d       = FALSE;
            lsb_done_d = TRUE;
            state_d    = ST_DONE;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            mem_a_d    = mem_a_q + ADDR_W'(1);
            mem_dout_d = wdata_q[7:0];
            wdata_d    = wdata_q >> 8;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      is_icache_q   <= FALSE;
      mem_a_q       <= NULL32;
      mem_dout_q    <= '0;
      wdata_q       <= NULL32;
      wr_q          <= FALSE;
      icache_done_q <= FALSE;
      lsb_done_q    <= FALSE;
      icache_data_q <= '0;
      lsb_rdata_q   <= NULL32;
      buf_q         <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      is_icache_q   <= is_icache_d;
      mem_a_q       <= mem_a_d;
      mem_dout_q    <= mem_dout_d;
      wdata_q       <= wdata_d;
      wr_q          <= wr_d;
      icache_done_q <= icache_done_d;
      lsb_done_q    <= lsb_done_d;
      icache_data_q <= icache_data_d;
      lsb_rdata_q   <= lsb_rdata_d;
      buf_q         <= buf_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with a byte RAM and a transaction-level reference
module tb_mem_ctrl;

  localparam int          LINE_BYTES = 4;
  localparam logic [31:0] IO_BASE    = 32'h30000;

  logic                    clk = 1'b0;
  logic                    rst, rdy;
  logic                    icache_req;
  logic [31:0]             icache_addr;
  logic                    icache_done;
  logic [8*LINE_BYTES-1:0] icache_data;
  logic                    lsb_req, lsb_wr;
  logic [31:0]             lsb_addr;
  logic [2:0]              lsb_len;
  logic [31:0]             lsb_wdata;
  logic                    lsb_done;
  logic [31:0]             lsb_rdata;
  logic                    flush;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;

  mem_ctrl #(.LINE_BYTES(LINE_BYTES), .IO_BASE(IO_BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_done    (icache_done),
    .icache_data    (icache_data),
    .lsb_req        (lsb_req),
    .lsb_wr         (lsb_wr),
    .lsb_addr       (lsb_addr),
    .lsb_len        (lsb_len),
    .lsb_wdata      (lsb_wdata),
    .lsb_done       (lsb_done),
    .lsb_rdata      (lsb_rdata),
    .flush          (flush),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // RAM is part of the frozen system: its read register only advances with rdy
  always @(posedge clk) begin
    if (rdy) mem_din <= ram.exists(mem_a) ? ram[mem_a] : init_byte(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    icache_req = 1'b0; lsb_req = 1'b0; lsb_wr = 1'b0;
    flush = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
  endtask

  // kind: 0 icache fill, 1 lsb load, 2 lsb store; latency counted in rdy-high edges
  task automatic xact(input int kind, input logic [31:0] a, input int n,
                      input logic [31:0] d, input bit rnd);
    int active, need, wrviol;
    bit got, was;
    need = (kind == 2) ? n + 1 : n + 2;
    if (kind == 0) begin
      icache_addr = a; icache_req = 1'b1; need = LINE_BYTES + 2;
    end else begin
      lsb_addr = a; lsb_len = 3'(n); lsb_wdata = d; lsb_wr = (kind == 2); lsb_req = 1'b1;
    end
    active = 0; got = 1'b0; wrviol = 0;
    for (int cyc = 0; cyc < 300 && !got; cyc++) begin
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      io_buffer_full = (a < IO_BASE) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if ((!rdy || kind != 2) && mem_wr) wrviol++;
      was = rdy;
      tick;
      if (was) active++;
      got = (kind == 0) ? icache_done : lsb_done;
    end
    check("x_done", 32'(got), 32'd1);
    check("x_lat", 32'(active), 32'(need));
    check("x_nowr", 32'(wrviol), 32'd0);
    if (kind == 0)      check("x_idata", icache_data, ref_load(a, LINE_BYTES));
    else if (kind == 1) check("x_rdata", lsb_rdata, ref_load(a, n));
    else                ref_store(a, n, d);
    idle_in;
    tick;
    tick;
  endtask

  initial begin
    logic [31:0] wd;
    logic [31:0] exp_a [4];
    int kind, n;
    logic [31:0] a;

    idle_in;
    rst = 1'b1;
    icache_addr = '0; lsb_addr = '0; lsb_len = 3'd0; lsb_wdata = '0;
    repeat (3) tick;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_dout", 32'(mem_dout), 32'h0);
    check("rst_wr", 32'(mem_wr), 32'h0);
    check("rst_idone", 32'(icache_done), 32'h0);
    check("rst_ldone", 32'(lsb_done), 32'h0);
    check("rst_idata", icache_data, 32'h0);
    check("rst_rdata", lsb_rdata, 32'h0);
    rst = 1'b0;
    tick;

    xact(2, 32'h100, 4, 32'h0000_0513, 1'b0);

    icache_addr = 32'h100; icache_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      if (c <= 4) check("fill_a", mem_a, 32'h100 + 32'(c - 1));
      check("fill_wr", 32'(mem_wr), 32'd0);
      check("fill_done", 32'(icache_done), 32'(c == 6));
    end
    check("fill_data", icache_data, 32'h0000_0513);
    idle_in; tick; tick;

    icache_addr = 32'h140; icache_req = 1'b1;
    lsb_addr = 32'h100; lsb_len = 3'd2; lsb_wr = 1'b0; lsb_req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 1) check("arb_lsb_first", mem_a, 32'h100);
      check("arb_idone", 32'(icache_done), 32'd0);
      check("arb_ldone", 32'(lsb_done), 32'(c == 4));
    end
    check("arb_rdata", lsb_rdata, 32'h0000_0513);
    lsb_req = 1'b0;
    for (int c = 5; c <= 11; c++) begin
      tick;
      if (c == 6) check("arb_icache_a", mem_a, 32'h140);
      check("arb_idone2", 32'(icache_done), 32'(c == 11));
    end
    check("arb_idata", icache_data, ref_load(32'h140, 4));
    icache_req = 1'b0;
    tick;
    icache_req = 1'b1; lsb_req = 1'b1; lsb_addr = 32'h180; lsb_len = 3'd1;
    tick;
    check("arb_rr_lsb", mem_a, 32'h180);
    tick; tick;
    check("arb_ldone2", 32'(lsb_done), 32'd1);
    check("arb_rdata2", lsb_rdata, ref_load(32'h180, 1));
    idle_in; tick; tick;

    icache_addr = 32'h300; icache_req = 1'b1;
    lsb_addr = 32'h1C0; lsb_len = 3'd4; lsb_wr = 1'b0; lsb_req = 1'b1;
    tick;
    check("fl_icache_won", mem_a, 32'h300);
    tick; tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick;
    check("fl_lsb_a", mem_a, 32'h1C0);
    for (int c = 6; c <= 12; c++) begin
      tick;
      if (c == 10) begin icache_req = 1'b0; lsb_req = 1'b0; end
      check("fl_no_idone", 32'(icache_done), 32'd0);
      check("fl_ldone", 32'(lsb_done), 32'(c == 10));
    end
    check("fl_rdata", lsb_rdata, ref_load(32'h1C0, 4));
    idle_in; tick;

    flush = 1'b1; lsb_req = 1'b1; lsb_addr = 32'h1E0; lsb_len = 3'd1; lsb_wr = 1'b0;
    tick;
    flush = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      tick;
      check("fl_idle_ldone", 32'(lsb_done), 32'(c == 4));
    end
    idle_in; tick; tick;

    wd = 32'hDEAD_BEEF;
    lsb_addr = 32'h200; lsb_len = 3'd4; lsb_wdata = wd; lsb_wr = 1'b1; lsb_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      check("st_wr", 32'(mem_wr), 32'(c <= 4));
      if (c <= 4) begin
        check("st_a", mem_a, 32'h200 + 32'(c - 1));
        check("st_dout", 32'(mem_dout), 32'(wd[8*(c-1) +: 8]));
      end
      check("st_done", 32'(lsb_done), 32'(c == 5));
    end
    ref_store(32'h200, 4, wd);
    idle_in; tick; tick;

    exp_a[0] = 32'h201; exp_a[1] = 32'h201; exp_a[2] = 32'h202; exp_a[3] = 32'h203;
    lsb_addr = 32'h200; lsb_len = 3'd4; lsb_wr = 1'b0; lsb_req = 1'b1;
    tick;
    tick;
    check("rdy_a_c2", mem_a, 32'h201);
    rdy = 1'b0;
    #1;
    check("rdy_wr_low", 32'(mem_wr), 32'd0);
    for (int c = 3; c <= 8; c++) begin
      tick;
      if (c == 4) rdy = 1'b1;
      if (c <= 6) check("rdy_a", mem_a, exp_a[c-3]);
      check("rdy_done", 32'(lsb_done), 32'(c == 8));
    end
    check("rdy_rdata", lsb_rdata, 32'hDEAD_BEEF);
    idle_in; tick; tick;

    lsb_addr = IO_BASE; lsb_len = 3'd1; lsb_wdata = 32'h0000_005A; lsb_wr = 1'b1;
    lsb_req = 1'b1; io_buffer_full = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick;
      check("io_stall_wr", 32'(mem_wr), 32'd0);
      check("io_stall_a", mem_a, IO_BASE);
    end
    tick;
    io_buffer_full = 1'b0;
    #1;
    check("io_wr", 32'(mem_wr), 32'd1);
    check("io_dout", 32'(mem_dout), 32'h5A);
    tick;
    check("io_done", 32'(lsb_done), 32'd1);
    check("io_wr_off", 32'(mem_wr), 32'd0);
    ref_store(IO_BASE, 1, 32'h5A);
    idle_in; tick; tick;

    lsb_addr = 32'h8000; lsb_len = 3'd4; lsb_wdata = 32'h1234_5678; lsb_wr = 1'b1; lsb_req = 1'b1;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; lsb_req = 1'b0;
    check("rstx_wr", 32'(mem_wr), 32'd0);
    check("rstx_a", mem_a, 32'h0);
    for (int c = 0; c < 6; c++) begin
      check("rstx_no_done", 32'(lsb_done), 32'd0);
      tick;
    end

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0: n = 1;
        1: n = 2;
        default: n = 4;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                      : 32'h1000 + 32'($urandom_range(0, 63));
      xact(kind, a, n, $urandom, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
